salsa20_stream_ctrl: RTL and testbench

SALSA20_STREAM_CTRL -- requirements
Module: salsa20_stream_ctrl

---
 rtl/salsa20_stream_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_salsa20_stream_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa20_stream_ctrl.sv
// Salsa20 stream-cipher controller.
// Builds the 64-byte Salsa20 input block from a latched key, nonce and block
// counter, starts an external hash core, captures its 64-byte output as
// keystream, and XORs it into a byte-wide valid/ready stream.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   cfg_load      one-cycle pulse latching cfg_key / cfg_nonce / cfg_ctr
//   cfg_key       32 key bytes (element i = key byte i)
//   cfg_nonce     8 nonce bytes (element i = nonce byte i)
//   cfg_ctr       initial 64-bit block counter
//   in_valid/in_ready/in_data     plaintext byte input
//   out_valid/out_ready/out_data  ciphertext byte output
//   hash_start    one-cycle start pulse to the hash core
//   hash_rounds   double-round count for the hash core
//   hash_x        hash input block (element i = byte i)
//   hash_valid    hash core done (level)
//   hash_z        hash output block (element i = byte i)
//   busy          high whenever the controller is not idle
module salsa20_stream_ctrl #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [31:0][7:0]     cfg_key,
  input  logic [7:0][7:0]      cfg_nonce,
  input  logic [63:0]          cfg_ctr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 hash_start,
  output logic [3:0]           hash_rounds,
  output logic [63:0][7:0]     hash_x,
  input  logic                 hash_valid,
  input  logic [63:0][7:0]     hash_z,
  output logic                 busy
);

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLK_BYTES   = 64;
  localparam int unsigned PTR_W       = 6;
  localparam int unsigned CTR_W       = 64;
  localparam int unsigned KEY_BYTES   = 32;
  localparam int unsigned HALF_KEY    = KEY_BYTES / 2;
  localparam int unsigned NONCE_BYTES = 8;
  localparam int unsigned RND_W       = 4;

  // "expand 32-byte k" as four little-endian words.
  localparam logic [31:0] SIGMA_0 = 32'h6170_7865;
  localparam logic [31:0] SIGMA_1 = 32'h3320_646e;
  localparam logic [31:0] SIGMA_2 = 32'h7962_2d32;
  localparam logic [31:0] SIGMA_3 = 32'h6b20_6574;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BLK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    WAIT,
    STREAM
  } state_t;

  state_t state_q, state_nxt;

  logic                                load_c;
  logic                                capture_c;
  logic                                take_c;

  logic [KEY_BYTES-1:0][BYTE_W-1:0]    key_q;
  logic [NONCE_BYTES-1:0][BYTE_W-1:0]  nonce_q;
  logic [CTR_W-1:0]                    ctr_q;
  logic [BLK_BYTES-1:0][BYTE_W-1:0]    ks_q;
  logic [PTR_W-1:0]                    ptr_q;

  assign hash_rounds = RND_W'(DOUBLE_ROUNDS);

  // Hash input block, assembled purely from latched registers so it holds
  // steady from the start pulse until the result is captured.
  always_comb begin
    hash_x = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      hash_x[PTR_W'(i)]      = SIGMA_0[5'(BYTE_W * i) +: BYTE_W];
      hash_x[PTR_W'(20 + i)] = SIGMA_1[5'(BYTE_W * i) +: BYTE_W];
      hash_x[PTR_W'(40 + i)] = SIGMA_2[5'(BYTE_W * i) +: BYTE_W];
      hash_x[PTR_W'(60 + i)] = SIGMA_3[5'(BYTE_W * i) +: BYTE_W];
    end
    for (int unsigned i = 0; i < HALF_KEY; i++) begin
      hash_x[PTR_W'(4 + i)]  = key_q[5'(i)];
      hash_x[PTR_W'(44 + i)] = key_q[5'(HALF_KEY + i)];
    end
    for (int unsigned i = 0; i < NONCE_BYTES; i++) begin
      hash_x[PTR_W'(24 + i)] = nonce_q[3'(i)];
      hash_x[PTR_W'(32 + i)] = ctr_q[6'(BYTE_W * i) +: BYTE_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and per-cycle control. in_ready must follow out_ready within
  // the cycle to allow full-rate streaming, so it is combinational.
  always_comb begin
    state_nxt = state_q;
    load_c    = 1'b0;
    capture_c = 1'b0;
    take_c    = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          load_c    = 1'b1;
          state_nxt = GEN;
        end
      end
      GEN: begin
        if (cfg_load) begin
          load_c    = 1'b1;
          state_nxt = GEN;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cfg_load) begin
          load_c    = 1'b1;
          state_nxt = GEN;
        end else if (hash_valid) begin
          capture_c = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        in_ready = !out_valid || out_ready;
        // A reload takes priority; a byte offered in the same cycle is dropped.
        if (cfg_load) begin
          load_c    = 1'b1;
          state_nxt = GEN;
        end else if (in_valid && in_ready) begin
          take_c = 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_nxt = GEN;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Configuration, keystream buffer, byte pointer and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      ks_q       <= '0;
      ptr_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      hash_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      hash_start <= (state_nxt == GEN);
      busy       <= (state_nxt != IDLE);
      if (load_c) begin
        key_q     <= cfg_key;
        nonce_q   <= cfg_nonce;
        ctr_q     <= cfg_ctr;
        ptr_q     <= '0;
        out_valid <= 1'b0;
      end else begin
        // Counter advances on capture so hash_x already shows the next block.
        if (capture_c) begin
          ks_q  <= hash_z;
          ptr_q <= '0;
          ctr_q <= ctr_q + CTR_W'(1);
        end
        // A pending byte stays valid across GEN/WAIT until it is taken.
        if (take_c) begin
          out_data  <= in_data ^ ks_q[ptr_q];
          out_valid <= 1'b1;
          ptr_q     <= ptr_q + PTR_W'(1);
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_salsa20_stream_ctrl.sv
// Testbench for salsa20_stream_ctrl: hash stub z[i] = x[i] ^ i after N cycles,
// keystream model derived from the Salsa20 block layout ("expand 32-byte k").
module tb_salsa20_stream_ctrl;

  localparam int unsigned DR = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_load;
  logic [31:0][7:0] cfg_key;
  logic [7:0][7:0] cfg_nonce;
  logic [63:0]     cfg_ctr;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            hash_start;
  logic [3:0]      hash_rounds;
  logic [63:0][7:0] hash_x;
  logic            hash_valid;
  logic [63:0][7:0] hash_z;
  logic            busy;

  salsa20_stream_ctrl #(.DOUBLE_ROUNDS(DR)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_ctr(cfg_ctr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .hash_start(hash_start),
    .hash_rounds(hash_rounds), .hash_x(hash_x), .hash_valid(hash_valid),
    .hash_z(hash_z), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Hash stub
  int              stub_n = 3;
  bit              stub_en = 1'b1;
  int              stub_cnt = 0;
  bit              stub_busy = 1'b0;
  logic            stub_valid = 1'b0;
  logic [63:0][7:0] stub_z = '0;
  logic            man_valid = 1'b0;
  logic [63:0][7:0] man_z = '0;

  assign hash_valid = stub_valid | man_valid;
  assign hash_z     = man_valid ? man_z : stub_z;

  always @(posedge clk) begin
    stub_valid <= 1'b0;
    if (!rst) begin
      stub_busy <= 1'b0;
    end else if (stub_en && hash_start) begin
      for (int i = 0; i < 64; i++) stub_z[i] <= hash_x[i] ^ 8'(i);
      if (stub_n == 0) begin
        stub_valid <= 1'b1;
      end else begin
        stub_cnt  <= stub_n - 1;
        stub_busy <= 1'b1;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        stub_valid <= 1'b1;
        stub_busy  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Monitor: accepted output bytes and counter seen at each start pulse.
  logic [7:0]  out_q[$];
  logic [63:0] ctr_seen[$];

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) out_q.push_back(out_data);
    if (rst && hash_start) begin
      logic [63:0] c;
      for (int i = 0; i < 8; i++) c[8*i +: 8] = hash_x[32+i];
      ctr_seen.push_back(c);
    end
  end

  // Reference model
  logic [31:0][7:0] key_t;
  logic [7:0][7:0]  nonce_t;
  logic [63:0]      ctr_t;
  int               ks_pos;
  logic [7:0]       exp_q[$];

  function automatic logic [7:0] blk_byte(input logic [31:0][7:0] k,
                                          input logic [7:0][7:0] n,
                                          input logic [63:0] c, input int idx);
    string sig;
    sig = "expand 32-byte k";
    if (idx < 4)       return 8'(sig[idx]);
    else if (idx < 20) return k[5'(idx - 4)];
    else if (idx < 24) return 8'(sig[idx - 16]);
    else if (idx < 32) return n[3'(idx - 24)];
    else if (idx < 40) return 8'(c >> (8 * (idx - 32)));
    else if (idx < 44) return 8'(sig[idx - 32]);
    else if (idx < 60) return k[5'(idx - 28)];
    else               return 8'(sig[idx - 48]);
  endfunction

  function automatic logic [7:0] ks_byte(input logic [31:0][7:0] k,
                                         input logic [7:0][7:0] n,
                                         input logic [63:0] c0, input int pos);
    return blk_byte(k, n, c0 + 64'(pos / 64), pos % 64) ^ 8'(pos % 64);
  endfunction

  task automatic rand_key_nonce(output logic [31:0][7:0] k, output logic [7:0][7:0] n);
    for (int i = 0; i < 32; i++) k[i] = 8'($urandom);
    for (int i = 0; i < 8; i++)  n[i] = 8'($urandom);
  endtask

  task automatic do_cfg(input logic [31:0][7:0] k, input logic [7:0][7:0] n,
                        input logic [63:0] c);
    key_t = k; nonce_t = n; ctr_t = c; ks_pos = 0;
    exp_q.delete();
    @(negedge clk);
    cfg_key = k; cfg_nonce = n; cfg_ctr = c; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic send_bytes(input int cnt, input bit rnd_data, input bit rnd_ready);
    for (int b = 0; b < cnt; b++) begin
      logic [7:0] d;
      int guard;
      bit done;
      d = rnd_data ? 8'($urandom) : 8'h00;
      guard = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        if (rnd_ready) out_ready = 1'($urandom);
        #1;
        if (in_ready) done = 1'b1;
        guard++;
        if (!done && guard > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: byte %0d never accepted, in_ready=%0b required 1", b, in_ready);
          in_valid = 1'b0;
          return;
        end
      end
      exp_q.push_back(d ^ ks_byte(key_t, nonce_t, ctr_t, ks_pos));
      ks_pos++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (hash_start !== 1'b0) begin errors++; $display("FAIL reset_hash_start: got %0b want 0", hash_start); end
    checks++; if (hash_rounds !== 4'(DR)) begin errors++; $display("FAIL reset_rounds: got %0d want %0d", hash_rounds, DR); end
    checks++; if (hash_x[32] !== 8'h00 || hash_x[39] !== 8'h00 || hash_x[4] !== 8'h00 || hash_x[24] !== 8'h00)
      begin errors++; $display("FAIL reset_regs: ctr/key/nonce bytes %h %h %h %h want 00", hash_x[32], hash_x[39], hash_x[4], hash_x[24]); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_layout();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    int bad;
    bit seen;
    for (int i = 0; i < 32; i++) k[i] = 8'(i);
    for (int i = 0; i < 8; i++) n[i] = 8'(8'hA0 + i);
    stub_n = 3;
    do_cfg(k, n, 64'h0102_0304_0506_0708);
    checks++; if (hash_start !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL layout_gen: hash_start=%0b busy=%0b want 1 1", hash_start, busy); end
    checks++; if ({hash_x[32], hash_x[33], hash_x[34], hash_x[35], hash_x[36], hash_x[37], hash_x[38], hash_x[39]} !== 64'h0807_0605_0403_0201)
      begin errors++; $display("FAIL layout_ctr: got %h%h%h%h%h%h%h%h want 0807060504030201", hash_x[32], hash_x[33], hash_x[34], hash_x[35], hash_x[36], hash_x[37], hash_x[38], hash_x[39]); end
    checks++; if ({hash_x[0], hash_x[1], hash_x[2], hash_x[3]} !== 32'h6578_7061)
      begin errors++; $display("FAIL layout_sigma: got %h%h%h%h want 65787061", hash_x[0], hash_x[1], hash_x[2], hash_x[3]); end
    checks++; if (hash_x[44] !== 8'h10) begin errors++; $display("FAIL layout_key16: got %h want 10", hash_x[44]); end
    checks++; if (hash_x[24] !== 8'hA0) begin errors++; $display("FAIL layout_nonce0: got %h want a0", hash_x[24]); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (hash_x[i] !== blk_byte(key_t, nonce_t, ctr_t, i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL layout_full: %0d bytes differ, want 0", bad); end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) if (hash_x[i] !== blk_byte(key_t, nonce_t, ctr_t, i)) bad++;
    checks++; if (hash_start !== 1'b0 || in_ready !== 1'b0 || bad != 0)
      begin errors++; $display("FAIL layout_wait: hash_start=%0b in_ready=%0b diff=%0d want 0 0 0", hash_start, in_ready, bad); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL layout_stream: in_ready=0 after 20 cycles, want 1"); end
  endtask

  task automatic test_stream();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    int ob, cb;
    rand_key_nonce(k, n);
    stub_n = 3;
    out_ready = 1'b1;
    ob = out_q.size();
    cb = ctr_seen.size();
    do_cfg(k, n, 64'd0);
    send_bytes(130, 1'b0, 1'b0);
    drain();
    checks++; if (out_q.size() - ob != 130) begin errors++; $display("FAIL stream_count: got %0d bytes want 130", out_q.size() - ob); end
    for (int i = 0; i < 130 && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL stream_byte%0d: got %h want %h", i, out_q[ob+i], exp_q[i]); end
    end
    checks++; if (ctr_seen.size() - cb != 3) begin errors++; $display("FAIL stream_starts: got %0d pulses want 3", ctr_seen.size() - cb); end
    for (int j = 0; j < 3 && cb + j < ctr_seen.size(); j++) begin
      checks++;
      if (ctr_seen[cb+j] !== 64'(j)) begin errors++; $display("FAIL stream_ctr%0d: got %h want %0d", j, ctr_seen[cb+j], j); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    logic [7:0] d1, d2, held;
    int ob;
    rand_key_nonce(k, n);
    stub_n = 3;
    out_ready = 1'b1;
    ob = out_q.size();
    do_cfg(k, n, {$urandom, $urandom});
    send_bytes(10, 1'b1, 1'b0);
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = d1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: in_ready=%0b want 1", in_ready); end
    held = d1 ^ ks_byte(key_t, nonce_t, ctr_t, ks_pos);
    exp_q.push_back(held); ks_pos++;
    @(negedge clk);
    in_data = d2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
        begin errors++; $display("FAIL bp_stall%0d: in_ready=%0b out_valid=%0b out_data=%h want 0 1 %h", c, in_ready, out_valid, out_data, held); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%0b want 1", in_ready); end
    exp_q.push_back(d2 ^ ks_byte(key_t, nonce_t, ctr_t, ks_pos)); ks_pos++;
    @(negedge clk);
    in_valid = 1'b0;
    send_bytes(60, 1'b1, 1'b1);
    drain();
    checks++; if (out_q.size() - ob != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d bytes want %0d", out_q.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, out_q[ob+i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    logic [63:0] c0;
    int ob, cb;
    rand_key_nonce(k, n);
    c0 = {$urandom, $urandom};
    stub_n = 0;
    ob = out_q.size();
    cb = ctr_seen.size();
    do_cfg(k, n, c0);
    send_bytes(200, 1'b1, 1'b1);
    drain();
    checks++; if (out_q.size() - ob != 200) begin errors++; $display("FAIL b2b_count: got %0d bytes want 200", out_q.size() - ob); end
    for (int i = 0; i < 200 && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, out_q[ob+i], exp_q[i]); end
    end
    checks++; if (ctr_seen.size() - cb != 4) begin errors++; $display("FAIL b2b_starts: got %0d want 4", ctr_seen.size() - cb); end
    for (int j = 0; j < 4 && cb + j < ctr_seen.size(); j++) begin
      checks++;
      if (ctr_seen[cb+j] !== c0 + 64'(j)) begin errors++; $display("FAIL b2b_ctr%0d: got %h want %h", j, ctr_seen[cb+j], c0 + 64'(j)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    int ob, cb;
    rand_key_nonce(k, n);
    stub_n = 0;
    ob = out_q.size();
    cb = ctr_seen.size();
    do_cfg(k, n, 64'hFFFF_FFFF_FFFF_FFFF);
    send_bytes(70, 1'b0, 1'b0);
    drain();
    checks++; if (ctr_seen.size() - cb != 2) begin errors++; $display("FAIL wrap_starts: got %0d want 2", ctr_seen.size() - cb); end
    if (ctr_seen.size() - cb >= 2) begin
      checks++;
      if (ctr_seen[cb+1] !== 64'd0) begin errors++; $display("FAIL wrap_ctr: got %h want 0", ctr_seen[cb+1]); end
    end
    checks++; if (out_q.size() - ob != 70) begin errors++; $display("FAIL wrap_count: got %0d want 70", out_q.size() - ob); end
    for (int i = 60; i < 70 && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, out_q[ob+i], exp_q[i]); end
    end
  endtask

  task automatic test_reload();
    logic [31:0][7:0] ka, kb;
    logic [7:0][7:0] na, nb;
    logic [63:0] cb_ctr;
    int ob;
    rand_key_nonce(ka, na);
    rand_key_nonce(kb, nb);
    cb_ctr = {$urandom, $urandom};
    stub_n = 3;
    ob = out_q.size();
    do_cfg(ka, na, {$urandom, $urandom});
    send_bytes(19, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'($urandom);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reload_b20: in_ready=%0b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reload_pending: out_valid=%0b want 1", out_valid); end
    out_ready = 1'b0;
    in_data = 8'($urandom);
    cfg_key = kb; cfg_nonce = nb; cfg_ctr = cb_ctr; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || hash_start !== 1'b1)
      begin errors++; $display("FAIL reload_gen: out_valid=%0b hash_start=%0b want 0 1", out_valid, hash_start); end
    key_t = kb; nonce_t = nb; ctr_t = cb_ctr; ks_pos = 0;
    send_bytes(8, 1'b1, 1'b0);
    drain();
    checks++; if (out_q.size() - ob != 27) begin errors++; $display("FAIL reload_count: got %0d want 27", out_q.size() - ob); end
    for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL reload_byte%0d: got %h want %h", i, out_q[ob+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0][7:0] k;
    logic [7:0][7:0] n;
    int ob;
    rand_key_nonce(k, n);
    stub_en = 1'b0;
    do_cfg(k, n, {$urandom, $urandom});
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rw_wait: busy=%0b in_ready=%0b want 1 0", busy, in_ready); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hash_start !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0 || hash_x[32] !== 8'h00 || hash_x[4] !== 8'h00)
      begin errors++; $display("FAIL rw_reset: busy=%0b start=%0b ov=%0b od=%h ir=%0b ctr0=%h key0=%h want all 0", busy, hash_start, out_valid, out_data, in_ready, hash_x[32], hash_x[4]); end
    @(negedge clk);
    rst = 1'b1;
    ob = out_q.size();
    for (int i = 0; i < 64; i++) man_z[i] = 8'($urandom);
    man_valid = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL rw_late%0d: ov=%0b busy=%0b ir=%0b want 0 0 0", c, out_valid, busy, in_ready); end
    end
    man_valid = 1'b0; in_valid = 1'b0;
    checks++; if (out_q.size() != ob) begin errors++; $display("FAIL rw_noout: got %0d bytes want 0", out_q.size() - ob); end
    stub_en = 1'b1;
  endtask

  initial begin
    cfg_load = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_ctr = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_layout();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reload();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
